// File: rtl/dec_countdown_unit_pkg.sv
// ----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the dec_countdown_unit slice.
//   state_e     : controller states (IDLE / RUN / HOLD)
//   MODE_SINGLE : single decrement request
//   MODE_COUNT  : iterative countdown request
// ----------------------------------------------------------------------------
package dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_COUNT  = 1'b1;

endpackage : dec_pkg

// File: rtl/dec_countdown_unit_operand_mux.sv
// ----------------------------------------------------------------------------
// dec_operand_mux
// WIDTH-bit 2:1 operand selector.
// Ports:
//   a_i   : operand A
//   b_i   : operand B
//   sel_i : 0 selects a_i, 1 selects b_i
//   y_o   : selected operand
// ----------------------------------------------------------------------------
module dec_operand_mux #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule : dec_operand_mux

// File: rtl/dec_countdown_unit.sv
// ----------------------------------------------------------------------------
// dec_countdown_unit
// Registered A/B decrementer with a single-step mode and an iterative
// countdown mode, wrapped in valid/ready handshakes.
//
// Build option:
//   DEC_SATURATE_EN : when defined, a negative true result clamps to 0
//                     (neg_flag still set). Otherwise results wrap mod 2^WIDTH.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   clr       : synchronous abort back to IDLE (result/flags retained)
//   in_valid  : request valid
//   in_ready  : request can be accepted (IDLE only)
//   a, b      : operands
//   sel       : 0 = a, 1 = b
//   mode      : 0 = SINGLE, 1 = COUNT
//   step      : COUNT decrement amount (0 behaves as 1)
//   out_valid : result valid (HOLD)
//   out_ready : consumer accepts result
//   result    : final value
//   neg_flag  : true result was below zero
//   zero_flag : result == 0
//   busy      : state != IDLE
// ----------------------------------------------------------------------------
module dec_countdown_unit #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              sel,
   input  logic              mode,
   input  logic [STEP_W-1:0] step,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              neg_flag,
   output logic              zero_flag,
   output logic              busy
);

   import dec_pkg::*;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Subtract with borrow detection; the borrow bit is returned as MSB.
   function automatic logic [WIDTH:0] dec_sub(input logic [WIDTH-1:0] m,
                                              input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] diff;
      logic             borrow;
      diff   = m - s;
      borrow = (m < s);
`ifdef DEC_SATURATE_EN
      if (borrow) diff = '0;
`endif
      return {borrow, diff};
   endfunction

   // Zero-extend the step and map 0 onto 1 so the countdown always advances.
   function automatic logic [WIDTH-1:0] norm_step(input logic [STEP_W-1:0] s);
      logic [WIDTH-1:0] ext;
      ext = WIDTH'(s);
      if (ext == '0) ext = ONE;
      return ext;
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] stp_q, stp_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             neg_q, neg_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] op;

   dec_operand_mux #(
      .WIDTH (WIDTH)
   ) u_operand_mux (
      .a_i   (a),
      .b_i   (b),
      .sel_i (sel),
      .y_o   (op)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stp_d    = stp_q;
      result_d = result_q;
      neg_d    = neg_q;

      if (clr) begin
         // Abort wins over everything; a same-cycle request is dropped.
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  stp_d = norm_step(step);
                  if (mode == MODE_SINGLE) begin
                     {neg_d, result_d} = dec_sub(op, ONE);
                     state_d           = HOLD;
                  end else if (op == '0) begin
                     result_d = '0;
                     neg_d    = 1'b0;
                     state_d  = HOLD;
                  end else begin
                     cnt_d   = op;
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               // Last iteration lands on or crosses zero and produces the result.
               if (cnt_q > stp_q) begin
                  cnt_d = cnt_q - stp_q;
               end else begin
                  {neg_d, result_d} = dec_sub(cnt_q, stp_q);
                  state_d           = HOLD;
               end
            end
            HOLD: begin
               if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         stp_q    <= ONE;
         result_q <= '0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stp_q    <= stp_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign neg_flag  = neg_q;
   assign zero_flag = zero_q;

endmodule : dec_countdown_unit

// File: tb/tb_dec_countdown_unit.sv
module tb_dec_countdown_unit;

   localparam int W  = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          sel = 1'b0;
   logic          mode = 1'b0;
   logic [SW-1:0] step = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          neg_flag;
   logic          zero_flag;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dec_countdown_unit #(.WIDTH(W), .STEP_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .mode      (mode),
      .step      (step),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .neg_flag  (neg_flag),
      .zero_flag (zero_flag),
      .busy      (busy)
   );

   typedef struct {
      logic          sel;
      logic          mode;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [SW-1:0] step;
      logic [W-1:0]  res;
      logic          neg;
      logic          zero;
      int            lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         neg;
      logic         zero;
      int           lat;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic m, input int av, input int bv,
                               input int st, input int r, input int n, input int z,
                               input int l);
      vec_t v;
      v.sel = s; v.mode = m; v.a = W'(av); v.b = W'(bv); v.step = SW'(st);
      v.res = W'(r); v.neg = n[0]; v.zero = z[0]; v.lat = l;
      return v;
   endfunction

   // Drive one request and return the observed latency (accept edge counts as 1).
   task automatic drive_and_wait(input vec_t v, output int lat);
      @(negedge clk);
      check("in_ready_before", in_ready, 1);
      in_valid = 1'b1; sel = v.sel; mode = v.mode; a = v.a; b = v.b; step = v.step;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_after_accept", in_ready, 0);
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input int idx);
      int   lat;
      exp_t e;
      out_ready = 1'b1;
      e.res = vecs[idx].res; e.neg = vecs[idx].neg; e.zero = vecs[idx].zero; e.lat = vecs[idx].lat;
      sb.push_back(e);
      drive_and_wait(vecs[idx], lat);
      e = sb.pop_front();
      if (!out_valid) begin
         check($sformatf("timeout_v%0d", idx), 0, 1);
      end else begin
         check($sformatf("result_v%0d", idx), result, e.res);
         check($sformatf("neg_v%0d", idx), neg_flag, e.neg);
         check($sformatf("zero_v%0d", idx), zero_flag, e.zero);
         check($sformatf("latency_v%0d", idx), lat, e.lat);
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("out_valid_drop_v%0d", idx), out_valid, 0);
   endtask

   initial begin
      int lat;
      vec_t v;

      //            sel  mode a   b  st  res neg zero lat
      vecs[0]  = mk(0,   0,   5,  0, 2,  4,  0,  0,   1);
`ifdef DEC_SATURATE_EN
      vecs[1]  = mk(1,   0,   7,  0, 0,  0,  1,  1,   1);
      vecs[2]  = mk(0,   1,  10,  0, 3,  0,  1,  1,   5);
      vecs[5]  = mk(1,   1,   0, 15, 2,  0,  1,  1,   9);
      vecs[6]  = mk(0,   1,   7,  0, 3,  0,  1,  1,   4);
      vecs[7]  = mk(0,   1,   2,  0, 3,  0,  1,  1,   2);
`else
      vecs[1]  = mk(1,   0,   7,  0, 0, 15,  1,  0,   1);
      vecs[2]  = mk(0,   1,  10,  0, 3, 14,  1,  0,   5);
      vecs[5]  = mk(1,   1,   0, 15, 2, 15,  1,  0,   9);
      vecs[6]  = mk(0,   1,   7,  0, 3, 14,  1,  0,   4);
      vecs[7]  = mk(0,   1,   2,  0, 3, 15,  1,  0,   2);
`endif
      vecs[3]  = mk(0,   1,   0,  9, 2,  0,  0,  1,   1);
      vecs[4]  = mk(1,   1,   3,  9, 3,  0,  0,  1,   4);
      vecs[8]  = mk(0,   0,   1,  0, 1,  0,  0,  1,   1);
      vecs[9]  = mk(0,   1,   3,  0, 0,  0,  0,  1,   4);
      vecs[10] = mk(0,   0,  11,  0, 1, 10,  0,  0,   1);

      // Reset state while rst_n is held low
      #12;
      check("rst_result", result, 0);
      check("rst_neg", neg_flag, 0);
      check("rst_zero", zero_flag, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 11; i++) run_vec(i);

      // clr mid-RUN: result from the previous request (10) must survive
      @(negedge clk);
      in_valid = 1'b1; sel = 1'b0; mode = 1'b1; a = 4'd12; step = 2'd1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("clr_pre_busy", busy, 1);
      @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      check("clr_in_ready", in_ready, 1);
      check("clr_out_valid", out_valid, 0);
      check("clr_busy", busy, 0);
      check("clr_result_kept", result, 10);
      // request presented together with clr is dropped
      in_valid = 1'b1; mode = 1'b0; a = 4'd5; clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; clr = 1'b0;
      check("clr_req_drop_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("clr_no_out_valid", out_valid, 0);
      end

      // Backpressure: COUNT a=8 step=0, consumer stalls for 4 cycles
      out_ready = 1'b0;
      v = mk(0, 1, 8, 0, 0, 0, 0, 1, 9);
      drive_and_wait(v, lat);
      check("bp_out_valid", out_valid, 1);
      check("bp_latency", lat, 9);
      check("bp_result", result, 0);
      check("bp_zero", zero_flag, 1);
      check("bp_neg", neg_flag, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_result", result, 0);
         check("bp_hold_zero", zero_flag, 1);
         check("bp_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);

      // Async reset while holding a SINGLE b=0 result
      out_ready = 1'b0;
      v = mk(1, 0, 3, 0, 0, 0, 0, 0, 1);
      drive_and_wait(v, lat);
      check("rh_out_valid_pre", out_valid, 1);
      check("rh_neg_pre", neg_flag, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rh_result", result, 0);
      check("rh_neg", neg_flag, 0);
      check("rh_zero", zero_flag, 0);
      check("rh_out_valid", out_valid, 0);
      check("rh_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rh_in_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dec_countdown_unit
